// File: rtl/demux_pkg.sv
// Shared constants and select decode for the 1-to-8 buffered demux.
package demux_pkg;

   localparam int NUM_OUT = 8;
   localparam int SEL_W   = 3;

   localparam logic [SEL_W-1:0] SEL_SLOT0 = 3'd0;
   localparam logic [SEL_W-1:0] SEL_SLOT1 = 3'd1;
   localparam logic [SEL_W-1:0] SEL_SLOT2 = 3'd2;
   localparam logic [SEL_W-1:0] SEL_SLOT3 = 3'd3;
   localparam logic [SEL_W-1:0] SEL_SLOT4 = 3'd4;
   localparam logic [SEL_W-1:0] SEL_SLOT5 = 3'd5;
   localparam logic [SEL_W-1:0] SEL_SLOT6 = 3'd6;
   localparam logic [SEL_W-1:0] SEL_SLOT7 = 3'd7;

   // Binary slot index to one-hot slot mask.
   function automatic logic [NUM_OUT-1:0] sel_decode(input logic [SEL_W-1:0] sel);
      sel_decode      = '0;
      sel_decode[sel] = 1'b1;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a valid/ready read side.
module demux_slot #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic full;

   // A write wins over a drain, so a simultaneous drain+write keeps the slot full.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (wr_en) begin
         full <= 1'b1;
         data <= wr_data;
      end else if (full && rd_ready) begin
         full <= 1'b0;
      end
   end

   assign valid = full;

endmodule

// File: rtl/demux_1to8_buf.sv
// Routes one producer word into one of eight one-entry slots with per-slot handshake.
// Optional zero-latency cut-through into an empty, ready slot: define DEMUX_1TO8_BYPASS_EN.
module demux_1to8_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   select,
   input  logic [WIDTH-1:0]   in_data,
   output logic [NUM_OUT-1:0] out_valid,
   input  logic [NUM_OUT-1:0] out_ready,
   output logic [WIDTH-1:0]   out_data_0,
   output logic [WIDTH-1:0]   out_data_1,
   output logic [WIDTH-1:0]   out_data_2,
   output logic [WIDTH-1:0]   out_data_3,
   output logic [WIDTH-1:0]   out_data_4,
   output logic [WIDTH-1:0]   out_data_5,
   output logic [WIDTH-1:0]   out_data_6,
   output logic [WIDTH-1:0]   out_data_7
);

   logic [NUM_OUT-1:0] full;
   logic [NUM_OUT-1:0] sel_hot;
   logic [NUM_OUT-1:0] bypass;
   logic [NUM_OUT-1:0] wr_en;
   logic [WIDTH-1:0]   slot_data [NUM_OUT];
   logic [WIDTH-1:0]   word      [NUM_OUT];
   logic               accept;

   assign sel_hot  = sel_decode(select);
   assign in_ready = !full[select] | out_ready[select];
   assign accept   = in_valid & in_ready;

`ifdef DEMUX_1TO8_BYPASS_EN
   // Cut-through only into an empty slot whose consumer is ready right now.
   assign bypass = (in_valid && reset && !full[select] && out_ready[select]) ? sel_hot : '0;
`else
   assign bypass = '0;
`endif

   assign wr_en = accept ? (sel_hot & ~bypass) : '0;

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_en[i]),
         .wr_data  (in_data),
         .rd_ready (out_ready[i]),
         .valid    (full[i]),
         .data     (slot_data[i])
      );

      assign out_valid[i] = full[i] | bypass[i];
      assign word[i]      = bypass[i] ? in_data : slot_data[i];
   end

   assign out_data_0 = word[SEL_SLOT0];
   assign out_data_1 = word[SEL_SLOT1];
   assign out_data_2 = word[SEL_SLOT2];
   assign out_data_3 = word[SEL_SLOT3];
   assign out_data_4 = word[SEL_SLOT4];
   assign out_data_5 = word[SEL_SLOT5];
   assign out_data_6 = word[SEL_SLOT6];
   assign out_data_7 = word[SEL_SLOT7];

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Scoreboard bench for demux_1to8_buf: per-slot expected-word queues, negedge monitor.
module tb_demux_1to8_buf;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] select = 3'd0;
   logic [3:0] in_data = 4'h0;
   logic [7:0] out_valid;
   logic [7:0] out_ready = 8'h00;
   logic [3:0] out_data_0, out_data_1, out_data_2, out_data_3;
   logic [3:0] out_data_4, out_data_5, out_data_6, out_data_7;
   wire  [3:0] od [8];

   int  n_checks = 0;
   int  n_errors = 0;
   bit  mon_en = 1'b0;
   bit  held = 1'b0;

   logic [3:0] exp_q [8][$];
   logic [3:0] last_word [8];

   always #5 clk = ~clk;

   demux_1to8_buf #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .select     (select),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data_0 (out_data_0),
      .out_data_1 (out_data_1),
      .out_data_2 (out_data_2),
      .out_data_3 (out_data_3),
      .out_data_4 (out_data_4),
      .out_data_5 (out_data_5),
      .out_data_6 (out_data_6),
      .out_data_7 (out_data_7)
   );

   assign od[0] = out_data_0;
   assign od[1] = out_data_1;
   assign od[2] = out_data_2;
   assign od[3] = out_data_3;
   assign od[4] = out_data_4;
   assign od[5] = out_data_5;
   assign od[6] = out_data_6;
   assign od[7] = out_data_7;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [3:0] d, input logic [7:0] rdy);
      @(posedge clk);
      #1;
      in_valid  = v;
      select    = s;
      in_data   = d;
      out_ready = rdy;
   endtask

   // Reference model: each slot is a queue of at most one pending word; the word
   // on a slot's output is whatever was last written into it (zero after reset).
   always @(negedge clk) begin
      logic [7:0] byp;
      logic [7:0] exp_valid;
      logic       exp_ready;
      logic       take;
      logic [3:0] popped;
      byp = 8'h00;
`ifdef DEMUX_1TO8_BYPASS_EN
      if (in_valid && reset && exp_q[select].size() == 0 && out_ready[select])
         byp[select] = 1'b1;
`endif
      exp_ready = (exp_q[select].size() == 0) || out_ready[select];
      take      = in_valid && exp_ready;
      if (mon_en) begin
         for (int n = 0; n < 8; n++)
            exp_valid[n] = (exp_q[n].size() != 0) || byp[n];
         checkOutput("out_valid", out_valid, exp_valid);
         checkOutput("in_ready", {7'd0, in_ready}, {7'd0, exp_ready});
         for (int n = 0; n < 8; n++)
            checkOutput($sformatf("out_data_%0d", n), {4'd0, od[n]},
                        {4'd0, byp[n] ? in_data : last_word[n]});
      end
      if (!reset) begin
         for (int n = 0; n < 8; n++) begin
            exp_q[n].delete();
            last_word[n] = 4'h0;
         end
      end else begin
         for (int n = 0; n < 8; n++) begin
            if (exp_q[n].size() != 0 && out_ready[n]) begin
               popped = exp_q[n].pop_front();
               if (mon_en)
                  checkOutput($sformatf("drain_%0d", n), {4'd0, od[n]}, {4'd0, popped});
            end
         end
         if (take && !byp[select]) begin
            exp_q[select].push_back(in_data);
            last_word[select] = in_data;
         end
      end
   end

   initial begin
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("reset_valid", out_valid, 8'h00);
      for (int n = 0; n < 8; n++)
         checkOutput($sformatf("reset_data_%0d", n), {4'd0, od[n]}, 8'h00);
      for (int s = 0; s < 8; s++) begin
         applyStimulus(1'b0, 3'(s), 4'h0, 8'h00);
         @(negedge clk);
         checkOutput("reset_in_ready", {7'd0, in_ready}, 8'h01);
      end

      $display("[TB] single delivery");
      applyStimulus(1'b1, 3'd5, 4'hA, 8'h00);
      applyStimulus(1'b0, 3'd0, 4'h0, 8'h00);
      @(negedge clk);
      checkOutput("single_valid", out_valid, 8'h20);
      checkOutput("single_data", {4'd0, od[5]}, 8'h0A);
      repeat (3) @(negedge clk);
      checkOutput("single_hold", {4'd0, od[5]}, 8'h0A);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 3'd5, 4'h3, 8'h00);
      @(negedge clk);
      checkOutput("bp_in_ready", {7'd0, in_ready}, 8'h00);
      checkOutput("bp_data_held", {4'd0, od[5]}, 8'h0A);
      applyStimulus(1'b1, 3'd5, 4'h3, 8'h20);
      @(negedge clk);
      checkOutput("bp_release_ready", {7'd0, in_ready}, 8'h01);
      applyStimulus(1'b0, 3'd0, 4'h0, 8'h00);
      @(negedge clk);
      checkOutput("bp_valid", out_valid, 8'h20);
      checkOutput("bp_data", {4'd0, od[5]}, 8'h03);
      applyStimulus(1'b0, 3'd0, 4'h0, 8'hFF);
      applyStimulus(1'b0, 3'd0, 4'h0, 8'h00);
      @(negedge clk);
      checkOutput("bp_drained", out_valid, 8'h00);

      $display("[TB] throughput");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, (i < 8) ? 3'(i) : 3'd2, 4'(i), 8'hFF);
         @(negedge clk);
         checkOutput("tp_in_ready", {7'd0, in_ready}, 8'h01);
      end
      applyStimulus(1'b0, 3'd0, 4'h0, 8'hFF);
      applyStimulus(1'b0, 3'd0, 4'h0, 8'h00);
      @(negedge clk);
      checkOutput("tp_empty", out_valid, 8'h00);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 3'd0, 4'h5, 8'h00);
      applyStimulus(1'b1, 3'd7, 4'h6, 8'h00);
      applyStimulus(1'b1, 3'd3, 4'h9, 8'h00);
      reset = 1'b0;
      applyStimulus(1'b0, 3'd0, 4'h0, 8'h00);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_valid", out_valid, 8'h00);
      checkOutput("midrst_data3", {4'd0, od[3]}, 8'h00);
      checkOutput("midrst_data7", {4'd0, od[7]}, 8'h00);

`ifdef DEMUX_1TO8_BYPASS_EN
      $display("[TB] bypass");
      applyStimulus(1'b1, 3'd1, 4'hC, 8'h02);
      @(negedge clk);
      checkOutput("byp_valid", out_valid, 8'h02);
      checkOutput("byp_data", {4'd0, od[1]}, 8'h0C);
      applyStimulus(1'b0, 3'd1, 4'h0, 8'h02);
      @(negedge clk);
      checkOutput("byp_after", out_valid, 8'h00);
`endif

      $display("[TB] random traffic");
      held = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #1;
         reset     = ($urandom_range(0, 99) != 0);
         out_ready = 8'($urandom) & 8'($urandom);
         if (!held) begin
            in_valid = ($urandom_range(0, 3) != 0);
            select   = 3'($urandom);
            in_data  = 4'($urandom);
         end
         @(negedge clk);
         held = in_valid && !in_ready && reset;
      end

      applyStimulus(1'b0, 3'd0, 4'h0, 8'hFF);
      reset = 1'b1;
      applyStimulus(1'b0, 3'd0, 4'h0, 8'h00);
      @(negedge clk);
      checkOutput("final_empty", out_valid, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/demux_1to8_buf.md
Name: demux_1to8_buf

Overview:
- Write-side counterpart of the 8-way read mux in the multi-cycle datapath.
- Takes one WIDTH-bit word plus a 3-bit select and routes it into one of eight one-entry holding slots.
- Each slot presents its word to its own consumer under a valid/ready handshake.
- Used wherever a single producer (e.g. result bus) feeds eight independent destinations that may stall independently.

Parameters:
- WIDTH, 4, data word width in bits; applies to in_data and every out_data_N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  1  producer has a word on in_data addressed by select.
- in_ready  output  1  block accepts the word this cycle.
- select  input  3  destination slot index 0..7, binary encoded (3'b000 = slot 0 … 3'b111 = slot 7).
- in_data  input  WIDTH  word to deliver.
- out_valid  output  8  bit N = slot N holds a word.
- out_ready  input  8  bit N = consumer N takes slot N's word this cycle.
- out_data_0 … out_data_7  output  WIDTH each  contents of slot N.

Behaviour:
- Reset (reset==0 at rising edge): all slot full flags cleared, all slot data registers cleared to 0. out_valid=8'h00, all out_data_N=0. in_ready follows the combinational rule below.
- Reset mid-operation: pending words are discarded and no output handshake completes that cycle.
- Per slot N state:
  - full[N]: 1 bit.
  - data[N]: WIDTH bits.
  - out_valid[N] = full[N].
  - out_data_N = data[N].
- in_ready = !full[select] | out_ready[select]. This is combinational from select and out_ready, which is allowed because out_ready does not depend on in_ready.
- Accept: in_valid & in_ready at the edge sets data[select] <= in_data and full[select] <= 1. Latency from accept to out_valid is 1 cycle.
- Drain: out_valid[N] & out_ready[N] at the edge clears full[N]. data[N] keeps its last value; it is not cleared.
- Drain and accept on the same slot in the same cycle: full stays 1 and data is replaced. This gives full throughput of one word per cycle per slot.
- Accept on slot A while slots B≠A drain: all updates are independent and happen in the same cycle.
- Slot full and its consumer not ready: in_ready=0 while select points at it. No data is overwritten and nothing is dropped.
- Producer rule: hold in_valid, select and in_data stable while in_valid & !in_ready. The block does not check this.
- out_data_N is stable while out_valid[N] & !out_ready[N].
- in_valid=0: no state change from the input side. select and in_data are don't-care.

Optional Feature:
- Macro: DEMUX_1TO8_BYPASS_EN.
- Defined: when in_valid & !full[select] & out_ready[select], the word cut-through happens with zero latency:
  - out_valid[select]=1 and out_data_select=in_data in the same cycle.
  - The slot is not written and stays empty.
  - All other cases behave as in the base design.
- Undefined: latency is always exactly 1 cycle and all outputs are purely registered.

Decomposition:
- Package demux_pkg:
  - NUM_OUT=8, SEL_W=3.
  - localparams SEL_SLOT0 … SEL_SLOT7 (3'd0 … 3'd7).
- Sub-module demux_slot (one-entry holding register, WIDTH parameter):
  - Ports: clk, reset, wr_en, wr_data, rd_ready, valid, data.
  - Instantiated 8 times; the top level holds only the select decode and in_ready mux.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → out_valid=8'h00, all out_data_N=0, in_ready=1 for any select.
- Single delivery: WIDTH=4, select=3'd5, in_data=4'hA, in_valid=1 for 1 cycle, out_ready=0 → next cycle out_valid=8'h20, out_data_5=4'hA, held indefinitely.
- Backpressure: slot 5 full, out_ready=0, present select=5, in_data=4'h3 → in_ready=0 and out_data_5 stays 4'hA. Then assert out_ready[5]=1 → in_ready=1, word accepted, next cycle out_data_5=4'h3, out_valid[5]=1.
- Throughput: out_ready=8'hFF, stream select=0,1,…,7 with data 4'h0..4'h7 back-to-back, then 8 more words to slot 2 → in_ready constantly 1, each word appears on its slot one cycle later, no loss.
- Reset mid-operation: slots 0 and 7 full, assert reset=0 for one cycle with in_valid=1 → out_valid=8'h00 afterwards and the presented word is not stored.
- Bypass (with DEMUX_1TO8_BYPASS_EN): slot 1 empty, out_ready[1]=1, select=1, in_data=4'hC → same-cycle out_valid[1]=1, out_data_1=4'hC, next cycle out_valid[1]=0.
